branch_predict_unit: RTL and testbench

- Execute-stage branch resolution unit with a built-in bimodal predictor.
- Fetch looks up a PC-indexed table of saturating counters to get a taken/not-taken prediction.
- Execute resolves the branch, computes targets, and flags mispredicts so fetch is redirected.
- Halt opcode puts the unit in a sticky halted state that pins the PC; hit/mispredict statistics are kept for perf reporting.

---
 rtl/bpu_pkg.sv | 27 ++
 rtl/branch_predict_unit_if.sv | 34 +++
 rtl/bht_table.sv | 40 ++++
 rtl/branch_predict_unit.sv | 97 +++++++++
 tb/tb_branch_predict_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types, constants and counter helper for the branch predict unit
package bpu_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } bpu_state_e;

    localparam logic [6:0] HALT_OPCODE_DEF = 7'b1111111;

    // Widest counter the helper supports; callers pass their real width.
    localparam int CTR_MAX_W = 8;

    function automatic logic [CTR_MAX_W-1:0] ctr_next(
        input logic [CTR_MAX_W-1:0] ctr,
        input logic                 taken,
        input int unsigned          ctr_w
    );
        logic [CTR_MAX_W-1:0] ctr_max;
        ctr_max = CTR_MAX_W'((32'd1 << ctr_w) - 32'd1);
        if (taken) begin
            return (ctr >= ctr_max) ? ctr : ctr + 1'b1;
        end
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch/execute signal bundle of the branch predict unit
interface branch_predict_unit_if #(
    parameter int PC_W = 9
);
    logic [PC_W-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     ex_imm;
    logic            ex_branch;
    logic [31:0]     ex_alu_result;
    logic [6:0]      ex_opcode;
    logic            ex_pred_taken;
    logic [31:0]     pc_imm;
    logic [31:0]     pc_four;
    logic [31:0]     br_pc;
    logic            pc_sel;
    logic            mispredict;
    logic            halted;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_alu_result, ex_opcode, ex_pred_taken,
        input  if_pred_taken, pc_imm, pc_four, br_pc, pc_sel, mispredict, halted,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_alu_result, ex_opcode, ex_pred_taken,
        output if_pred_taken, pc_imm, pc_four, br_pc, pc_sel, mispredict, halted,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/bht_table.sv
// rtl/bht_table.sv - bimodal saturating-counter table, one fetch read port and one execute update port
module bht_table
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    // Weakly-not-taken: one below the taken threshold (0 for single-bit counters).
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((32'd1 << (CTR_W - 1)) - 32'd1);

    logic [CTR_W-1:0]     tbl [ENTRIES];
    logic [CTR_MAX_W-1:0] nxt_wide;
    logic [CTR_W-1:0]     nxt;
    logic                 unused_hi;

    assign rd_ctr    = tbl[rd_idx];
    assign nxt_wide  = ctr_next(CTR_MAX_W'(tbl[upd_idx]), upd_taken, CTR_W);
    assign nxt       = nxt_wide[CTR_W-1:0];
    assign unused_hi = ^nxt_wide;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            tbl[upd_idx] <= nxt;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - execute-stage branch resolution with bimodal prediction, halt and stats
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int         PC_W        = 9,
    parameter int         BHT_ENTRIES = 16,
    parameter int         CTR_W       = 2,
    parameter logic [6:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_predict_unit_if.slave   bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bpu_state_e       state;
    logic [31:0]      halt_pc_q;
    logic [31:0]      stat_br_q;
    logic [31:0]      stat_mp_q;
    logic [31:0]      pc_full;
    logic [CTR_W-1:0] rd_ctr;
    logic             actual;
    logic             halt_hit;
    logic             is_halted;
    logic             mp;
    logic             upd_en;
    logic             unused_bits;

    assign pc_full     = 32'(bus.ex_pc);
    assign is_halted   = (state == HALTED);
    assign actual      = bus.ex_branch & bus.ex_alu_result[0];
    assign halt_hit    = bus.ex_valid & (bus.ex_opcode == HALT_OPCODE);
    assign mp          = bus.ex_valid & ~halt_hit & ~is_halted & (actual != bus.ex_pred_taken);
    assign upd_en      = bus.ex_valid & bus.ex_branch & ~halt_hit & ~is_halted;
    assign unused_bits = ^{bus.if_pc, bus.ex_alu_result};

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .CTR_W   (CTR_W)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (bus.if_pc[IDX_W+1:2]),
        .rd_ctr    (rd_ctr),
        .upd_en    (upd_en),
        .upd_idx   (bus.ex_pc[IDX_W+1:2]),
        .upd_taken (actual)
    );

    assign bus.if_pred_taken    = rd_ctr[CTR_W-1];
    assign bus.pc_four          = pc_full + 32'd4;
    assign bus.pc_imm           = halt_hit ? pc_full : pc_full + bus.ex_imm;
    assign bus.mispredict       = mp;
    assign bus.pc_sel           = is_halted | halt_hit | mp;
    assign bus.halted           = is_halted;
    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;

    always_comb begin
        bus.br_pc = 32'd0;
        if (is_halted) begin
            bus.br_pc = halt_pc_q;
        end else if (halt_hit) begin
            bus.br_pc = pc_full;
        end else if (mp) begin
            bus.br_pc = actual ? bus.pc_imm : bus.pc_four;
        end
    end

    // Halt is sticky: once entered only reset leaves, and every update is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            halt_pc_q <= 32'd0;
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_hit) begin
                        state     <= HALTED;
                        halt_pc_q <= pc_full;
                    end
                    if (upd_en && stat_br_q != 32'hFFFF_FFFF) begin
                        stat_br_q <= stat_br_q + 32'd1;
                    end
                    if (mp && stat_mp_q != 32'hFFFF_FFFF) begin
                        stat_mp_q <= stat_mp_q + 32'd1;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - randomized and directed bench for branch_predict_unit against a reference model
module tb_branch_predict_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.PC_W(9)) bus ();

    branch_predict_unit #(
        .PC_W        (9),
        .BHT_ENTRIES (16),
        .CTR_W       (2),
        .HALT_OPCODE (7'h7F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference state: counters as plain integers 0..3, taken when >= 2.
    int          m_bht [16];
    int unsigned m_br, m_mp, m_halt_pc;
    bit          m_halted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_br = 0; m_mp = 0; m_halt_pc = 0; m_halted = 0;
    endtask

    task automatic idle();
        bus.if_pc = '0; bus.ex_valid = 0; bus.ex_pc = '0; bus.ex_imm = '0;
        bus.ex_branch = 0; bus.ex_alu_result = '0; bus.ex_opcode = '0; bus.ex_pred_taken = 0;
    endtask

    function automatic bit is_mp();
        bit act = bus.ex_branch && bus.ex_alu_result[0];
        bit hh  = bus.ex_valid && (bus.ex_opcode == 7'h7F);
        return bus.ex_valid && !hh && !m_halted && (act != bus.ex_pred_taken);
    endfunction

    // Drive one execute/fetch pair and compare every combinational output to the model.
    task automatic apply(input logic [8:0] ipc, input bit v, input logic [8:0] pc,
                         input logic [31:0] imm, input bit br, input logic [31:0] alu,
                         input logic [6:0] op, input bit pt);
        int unsigned pcf, exp_br;
        bit act, hh, mp;
        bus.if_pc = ipc; bus.ex_valid = v; bus.ex_pc = pc; bus.ex_imm = imm;
        bus.ex_branch = br; bus.ex_alu_result = alu; bus.ex_opcode = op; bus.ex_pred_taken = pt;
        #1;
        pcf = 32'(pc);
        act = br && alu[0];
        hh  = v && (op == 7'h7F);
        mp  = is_mp();
        if (m_halted)  exp_br = m_halt_pc;
        else if (hh)   exp_br = pcf;
        else if (mp)   exp_br = act ? pcf + imm : pcf + 4;
        else           exp_br = 0;
        check("if_pred_taken", 32'(bus.if_pred_taken), 32'(m_bht[(ipc / 4) % 16] >= 2));
        check("mispredict", 32'(bus.mispredict), 32'(mp));
        check("pc_sel", 32'(bus.pc_sel), 32'(m_halted || hh || mp));
        check("br_pc", bus.br_pc, exp_br);
        check("pc_imm", bus.pc_imm, hh ? pcf : pcf + imm);
        check("pc_four", bus.pc_four, pcf + 4);
        check("halted", 32'(bus.halted), 32'(m_halted));
        check("stat_branches", bus.stat_branches, m_br);
        check("stat_mispredicts", bus.stat_mispredicts, m_mp);
    endtask

    task automatic tick();
        bit act = bus.ex_branch && bus.ex_alu_result[0];
        bit hh  = bus.ex_valid && (bus.ex_opcode == 7'h7F);
        bit mp  = is_mp();
        int idx = (int'(bus.ex_pc) / 4) % 16;
        @(posedge clk);
        if (!m_halted) begin
            if (hh) begin
                m_halted  = 1;
                m_halt_pc = 32'(bus.ex_pc);
            end else begin
                if (bus.ex_valid && bus.ex_branch) begin
                    m_bht[idx] = act ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                     : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
                    if (m_br != 32'hFFFF_FFFF) m_br++;
                end
                if (mp && m_mp != 32'hFFFF_FFFF) m_mp++;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_step(input bit allow_halt);
        logic [8:0]  pc  = 9'($urandom_range(0, 511));
        logic [8:0]  ipc = ($urandom_range(0, 3) == 0) ? pc : 9'($urandom_range(0, 511));
        logic [6:0]  op  = 7'($urandom_range(0, 126));
        if (allow_halt && $urandom_range(0, 39) == 0) op = 7'h7F;
        apply(ipc, $urandom_range(0, 9) != 0, pc, $urandom, $urandom_range(0, 9) < 7,
              $urandom, op, 1'($urandom_range(0, 1)));
        tick();
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        model_reset();
        #2;
        check("rst_pc_sel", 32'(bus.pc_sel), 0);
        check("rst_mispredict", 32'(bus.mispredict), 0);
        check("rst_br_pc", bus.br_pc, 0);
        check("rst_halted", 32'(bus.halted), 0);
        check("rst_pred", 32'(bus.if_pred_taken), 0);
        check("rst_stats", bus.stat_branches | bus.stat_mispredicts, 0);
        #1 reset = 1;
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        @(negedge clk);
        do_reset();

        // First taken branch against a not-taken prediction.
        apply(9'h10, 1, 9'h10, 32'h20, 1, 32'h1, 7'h63, 0);
        check("tp1_mispredict", 32'(bus.mispredict), 1);
        check("tp1_br_pc", bus.br_pc, 32'h30);
        tick();
        apply(9'h10, 1, 9'h10, 32'h20, 1, 32'h1, 7'h63, 1);
        tick();
        apply(9'h50, 0, 9'h10, 0, 0, 0, 0, 0);
        check("alias_pred", 32'(bus.if_pred_taken), 1);
        check("tp2_branches", bus.stat_branches, 2);
        check("tp2_mispredicts", bus.stat_mispredicts, 1);
        tick();

        // Saturate, then one not-taken keeps the prediction taken.
        for (int i = 0; i < 2; i++) begin
            apply(9'h10, 1, 9'h10, 32'h20, 1, 32'h1, 7'h63, 1);
            tick();
        end
        apply(9'h10, 1, 9'h10, 32'h20, 1, 32'h0, 7'h63, 1);
        tick();
        apply(9'h10, 0, 9'h10, 0, 0, 0, 0, 0);
        check("sat_pred", 32'(bus.if_pred_taken), 1);
        tick();

        // Non-branch carrying a taken prediction.
        apply(9'h08, 1, 9'h08, 32'h100, 0, 32'h1, 7'h13, 1);
        check("nb_mispredict", 32'(bus.mispredict), 1);
        check("nb_br_pc", bus.br_pc, 32'h0C);
        tick();
        apply(9'h08, 0, 9'h08, 0, 0, 0, 0, 0);
        check("nb_pred", 32'(bus.if_pred_taken), 0);
        check("nb_mispredicts", bus.stat_mispredicts, 3);
        check("nb_branches", bus.stat_branches, 5);
        tick();

        // Same-cycle read and update of index 4.
        apply(9'h10, 1, 9'h10, 32'h4, 1, 32'h0, 7'h63, 1);
        check("rw_old", 32'(bus.if_pred_taken), 1);
        tick();
        apply(9'h10, 0, 9'h10, 0, 0, 0, 0, 0);
        check("rw_new", 32'(bus.if_pred_taken), 0);
        tick();

        for (int i = 0; i < 200; i++) rand_step(0);

        // Halt and confirm it is sticky.
        apply(9'h0, 1, 9'h40, 32'h80, 1, 32'h1, 7'h7F, 0);
        check("halt_pc_sel", 32'(bus.pc_sel), 1);
        check("halt_br_pc", bus.br_pc, 32'h40);
        check("halt_pc_imm", bus.pc_imm, 32'h40);
        tick();
        check("halt_state", 32'(bus.halted), 1);
        for (int i = 0; i < 12; i++) begin
            rand_step(1);
            check("halt_pinned", bus.br_pc, 32'h40);
        end
        do_reset();
        check("halt_cleared", 32'(bus.halted), 0);

        for (int i = 0; i < 200; i++) rand_step(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
